// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, midpoint sampling, glitch reject, framing error.
// Latency: valid_o/framing_err_o rise on the edge that samples the stop-bit midpoint.
// No backpressure: the consumer must take data_o on the single cycle valid_o is high.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial line, asynchronous to clk, idle high
//   data_o        last correctly framed byte (LSB received first), held until the next good frame
//   valid_o       one-cycle pulse, data_o valid this cycle
//   framing_err_o one-cycle pulse, stop bit sampled low
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       framing_err_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);

    // Half-bit uses integer division, so odd divisors sample slightly early.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLOCKS_PER_BAUD - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic             rx_m;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronizer resets to the idle level so release never looks like a start bit.
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            state         <= S_IDLE;
            baud_cnt      <= '0;
            bit_idx       <= 3'd0;
            shift_q       <= 8'h00;
            data_o        <= 8'h00;
            valid_o       <= 1'b0;
            framing_err_o <= 1'b0;
        end else begin
            rx_m          <= rx;
            rx_s          <= rx_m;
            valid_o       <= 1'b0;
            framing_err_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (baud_cnt == HALF_M1) begin
                        // Mid start bit: still low means a real frame, high means a glitch.
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_q  <= {rx_s, shift_q[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            data_o  <= shift_q;
                            valid_o <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            framing_err_o <= 1'b1;
                            state         <= S_WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    // Break / line held low: wait for the line to return high before rearming.
                    baud_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
